// File: rtl/shift_pkg.sv
// Shared types and helpers for the stream serializer.
package shift_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Word-in / beat-out handshake bundle of the stream serializer.
interface stream_serializer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_en;
  logic             ser_valid;
  logic [LANES-1:0] ser_out;
  logic             last;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output flush, in_valid, in_data, ser_en,
    input  in_ready, ser_valid, ser_out, last, busy, word_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, ser_en,
    output in_ready, ser_valid, ser_out, last, busy, word_cnt
  );
endinterface

// File: rtl/stream_serializer_cnt.sv
// Up/down counter primitive; wraps modulo 2^WIDTH, clr has priority over en.
module stream_serializer_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = up ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end
endmodule

// File: rtl/stream_serializer_reg.sv
// Enabled register primitive with asynchronous active-low reset to zero.
module stream_serializer_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/stream_serializer.sv
// Parallel-in/serial-out engine: LANES bits per beat, one-word holding buffer
// so back-to-back words stream without an idle beat, plus a completed-word counter.
module stream_serializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst_b,
  stream_serializer_if.slave  bus
);
  localparam int unsigned BEATS = beats(WIDTH, LANES);
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("stream_serializer: WIDTH must be a multiple of LANES");
  end

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic [BCW-1:0]   beat_q, beat_d;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid, hold_valid_d, hold_load;
  logic             accept, consume, last_beat, word_done;

  assign bus.in_ready  = ~hold_valid & ~bus.flush;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.ser_valid = (state_q == S_SHIFT);
  assign bus.busy      = bus.ser_valid | hold_valid;
  assign last_beat     = (beat_q == BCW'(BEATS - 1));
  assign bus.last      = bus.ser_valid & last_beat;
  assign consume       = bus.ser_valid & bus.ser_en;
  // A flush in the same cycle swallows the final beat, so it is not counted.
  assign word_done     = consume & last_beat & ~bus.flush;

  if (MSB_FIRST) begin : g_msb
    assign bus.ser_out = sreg_q[WIDTH-1 -: LANES];
    if (LANES < WIDTH) begin : g_shift
      assign sreg_shift = {sreg_q[WIDTH-LANES-1:0], {LANES{1'b0}}};
    end else begin : g_noshift
      assign sreg_shift = '0;
    end
  end else begin : g_lsb
    assign bus.ser_out = sreg_q[LANES-1:0];
    if (LANES < WIDTH) begin : g_shift
      assign sreg_shift = {{LANES{1'b0}}, sreg_q[WIDTH-1:LANES]};
    end else begin : g_noshift
      assign sreg_shift = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    beat_d       = beat_q;
    hold_load    = 1'b0;
    hold_valid_d = hold_valid;
    if (bus.flush) begin
      state_d      = S_IDLE;
      sreg_d       = '0;
      beat_d       = '0;
      hold_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            sreg_d  = bus.in_data;
            beat_d  = '0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (consume && last_beat) begin
            beat_d = '0;
            if (hold_valid) begin
              sreg_d       = hold_data;
              hold_valid_d = 1'b0;
            end else if (accept) begin
              sreg_d = bus.in_data;
            end else begin
              // Zeroing on idle entry keeps ser_out at 0 while nothing is valid.
              sreg_d  = '0;
              state_d = S_IDLE;
            end
          end else begin
            if (consume) begin
              sreg_d = sreg_shift;
              beat_d = beat_q + BCW'(1);
            end
            if (accept) begin
              hold_load    = 1'b1;
              hold_valid_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      beat_q  <= beat_d;
    end
  end

  stream_serializer_reg #(
    .WIDTH(WIDTH)
  ) u_hold_data (
    .clk  (clk),
    .rst_b(rst_b),
    .en   (hold_load),
    .d    (bus.in_data),
    .q    (hold_data)
  );

  stream_serializer_reg #(
    .WIDTH(1)
  ) u_hold_valid (
    .clk  (clk),
    .rst_b(rst_b),
    .en   (1'b1),
    .d    (hold_valid_d),
    .q    (hold_valid)
  );

  stream_serializer_cnt #(
    .WIDTH(CNT_W)
  ) u_word_cnt (
    .clk  (clk),
    .rst_b(rst_b),
    .clr  (1'b0),
    .en   (word_done),
    .up   (1'b1),
    .q    (bus.word_cnt)
  );
endmodule

// File: tb/tb_stream_serializer.sv
// Randomized scoreboard bench for stream_serializer over three configurations:
// 8b/1 lane LSB-first (2-bit counter), 8b/2 lanes MSB-first, 8b/8 lanes (one beat per word).
module tb_stream_serializer;
  logic clk;
  logic rst_b;
  int   tests;
  int   fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input int cfg, input string what, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL cfg%0d %s: got %0d, expected %0d (t=%0t)", cfg, what, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned L  = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    localparam bit          M  = (g == 1);
    localparam int unsigned CW = (g == 0) ? 2 : (g == 1) ? 16 : 4;
    localparam int          NB = 8 / L;

    stream_serializer_if #(.WIDTH(8), .LANES(L), .CNT_W(CW)) bus ();

    stream_serializer #(
      .WIDTH    (8),
      .LANES    (L),
      .MSB_FIRST(M),
      .CNT_W    (CW)
    ) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus)
    );

    logic       in_valid;
    logic       flush;
    logic       ser_en;
    logic [7:0] in_data;
    assign bus.in_valid = in_valid;
    assign bus.flush    = flush;
    assign bus.ser_en   = ser_en;
    assign bus.in_data  = in_data;

    // Expected beats in emission order: bits [7:0] = beat value, bit 8 = final beat of word.
    int exp_q[$];
    bit exp_ready;
    int cnt;

    // Driver: records each accepted word as its expected beat sequence.
    initial begin : drive
      int sh;
      int mask;
      int pv, pe, pf;
      in_valid = 1'b0;
      flush    = 1'b0;
      ser_en   = 1'b0;
      in_data  = 8'h00;
      mask     = (1 << L) - 1;
      for (int c = 0; c < 800; c++) begin
        @(posedge clk);
        if (!rst_b || flush) begin
          exp_q.delete();
        end else if (in_valid && exp_ready) begin
          for (int k = 0; k < NB; k++) begin
            sh = M ? (8 - (k + 1) * L) : (k * L);
            exp_q.push_back(((int'(in_data) >> sh) & mask) | ((k == NB - 1) ? 256 : 0));
          end
        end
        #1;
        if (c < 200) begin
          pv = 90; pe = 100; pf = 0;
        end else if (c < 450) begin
          pv = 60; pe = 55; pf = 3;
        end else if (c < 760) begin
          pv = 40; pe = 85; pf = 2;
        end else begin
          pv = 0; pe = 100; pf = 0;
        end
        in_valid = ($urandom_range(0, 99) < pv);
        ser_en   = ($urandom_range(0, 99) < pe);
        flush    = ($urandom_range(0, 99) < pf);
        in_data  = 8'($urandom);
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      ser_en   = 1'b1;
    end

    // Monitor: compares the presented beat and status against the queue head.
    always @(negedge clk) begin
      int words;
      int head;
      if (!rst_b) begin
        check(g, "rst ser_valid", int'(bus.ser_valid), 0);
        check(g, "rst busy", int'(bus.busy), 0);
        check(g, "rst ser_out", int'(bus.ser_out), 0);
        check(g, "rst last", int'(bus.last), 0);
        check(g, "rst word_cnt", int'(bus.word_cnt), 0);
        check(g, "rst in_ready", int'(bus.in_ready), int'(!flush));
        exp_q.delete();
        cnt       = 0;
        exp_ready = !flush;
      end else begin
        words = 0;
        foreach (exp_q[i]) if (exp_q[i] >= 256) words++;
        check(g, "ser_valid", int'(bus.ser_valid), int'(exp_q.size() > 0));
        check(g, "busy", int'(bus.busy), int'(exp_q.size() > 0));
        check(g, "in_ready", int'(bus.in_ready), int'(words < 2 && !flush));
        check(g, "word_cnt", int'(bus.word_cnt), cnt % (1 << CW));
        exp_ready = (words < 2) && !flush;
        if (exp_q.size() > 0) begin
          head = exp_q[0];
          check(g, "ser_out", int'(bus.ser_out), head & 255);
          check(g, "last", int'(bus.last), int'(head >= 256));
          if (ser_en && !flush) begin
            void'(exp_q.pop_front());
            if (head >= 256) cnt++;
          end
        end else begin
          check(g, "idle ser_out", int'(bus.ser_out), 0);
          check(g, "idle last", int'(bus.last), 0);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_b = 1'b0;
    #12 rst_b = 1'b1;
    repeat (300) @(posedge clk);
    // Asynchronous reset pulse mid-stream, checked before any further clock edge.
    #3 rst_b = 1'b0;
    @(negedge clk);
    #2 rst_b = 1'b1;
    repeat (520) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
